// File: rtl/namco_wsg_pkg.sv
// Shared definitions for the N-voice Namco wave sound generator:
// FSM states, register offsets and width helpers.
package namco_wsg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_WAIT = 3'd2,
        ST_MAC  = 3'd3,
        ST_OUT  = 3'd4
    } wsg_state_t;

    localparam logic [2:0] REG_FREQ0 = 3'd0;
    localparam logic [2:0] REG_FREQ1 = 3'd1;
    localparam logic [2:0] REG_FREQ2 = 3'd2;
    localparam logic [2:0] REG_FREQ3 = 3'd3;
    localparam logic [2:0] REG_FREQ4 = 3'd4;
    localparam logic [2:0] REG_WAVE  = 3'd5;
    localparam logic [2:0] REG_VOL   = 3'd6;
    localparam logic [2:0] REG_RSVD  = 3'd7;

    // Mix accumulator: 8-bit products summed over all voices.
    function automatic int unsigned sum_width(input int unsigned voices);
        return 8 + $clog2(voices);
    endfunction

    function automatic int unsigned voice_idx_w(input int unsigned voices);
        return (voices > 1) ? $clog2(voices) : 1;
    endfunction

    function automatic int unsigned addr_w(input int unsigned voices);
        return $clog2(voices) + 3;
    endfunction

endpackage

// File: rtl/namco_wsg_regs.sv
// Per-voice frequency/wave/volume register file with nibble write decode
// and a combinational read port for the voice being serviced.
module namco_wsg_regs
    import namco_wsg_pkg::*;
#(
    parameter int unsigned VOICES = 3,
    parameter int unsigned ACC_W  = 20
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_wr,
    input  logic [addr_w(VOICES)-1:0]         i_ad,
    input  logic [3:0]                        i_di,
    input  logic [voice_idx_w(VOICES)-1:0]    i_rd_v,
    output logic [ACC_W-1:0]                  o_freq,
    output logic [2:0]                        o_wave,
    output logic [3:0]                        o_vol
);

    localparam int unsigned AW  = addr_w(VOICES);
    localparam int unsigned VIW = voice_idx_w(VOICES);

    logic [ACC_W-1:0] r_freq [VOICES];
    logic [2:0]       r_wave [VOICES];
    logic [3:0]       r_vol  [VOICES];

    logic [AW-1:0]    w_vsel;
    logic [VIW-1:0]   w_voice;
    logic [2:0]       w_reg;
    logic             w_hit;
    logic [ACC_W-1:0] w_nib_data;
    logic [ACC_W-1:0] w_nib_mask;

    assign w_vsel  = i_ad >> 3;
    assign w_voice = VIW'(w_vsel);
    assign w_reg   = i_ad[2:0];
    assign w_hit   = i_wr && (32'(w_vsel) < VOICES) && (w_reg != REG_RSVD);

    // Nibbles lying above ACC_W fall off in the truncating cast.
    assign w_nib_data = ACC_W'({16'b0, i_di}  << {w_reg, 2'b00});
    assign w_nib_mask = ACC_W'({16'b0, 4'hF} << {w_reg, 2'b00});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned v = 0; v < VOICES; v++) begin
                r_freq[v] <= '0;
                r_wave[v] <= '0;
                r_vol[v]  <= '0;
            end
        end else if (w_hit) begin
            for (int unsigned v = 0; v < VOICES; v++) begin
                if (w_voice == VIW'(v)) begin
                    case (w_reg)
                        REG_WAVE: r_wave[v] <= i_di[2:0];
                        REG_VOL:  r_vol[v]  <= i_di;
                        default:  r_freq[v] <= (r_freq[v] & ~w_nib_mask) | w_nib_data;
                    endcase
                end
            end
        end
    end

    assign o_freq = r_freq[i_rd_v];
    assign o_wave = r_wave[i_rd_v];
    assign o_vol  = r_vol[i_rd_v];

endmodule

// File: rtl/namco_wsg_nv.sv
// N-voice time-multiplexed wavetable synthesiser: one frame per sample tick
// walks every voice through ADDR/WAIT/MAC, then mixes and strobes the result.
module namco_wsg_nv
    import namco_wsg_pkg::*;
#(
    parameter int unsigned VOICES  = 3,
    parameter int unsigned ACC_W   = 20,
    parameter int unsigned DIV     = 500,
    parameter int unsigned MIX_SAT = 0
) (
    input  logic                      MCLK,
    input  logic                      RESET_N,
    input  logic                      EN,
    input  logic                      WR,
    input  logic [addr_w(VOICES)-1:0] AD,
    input  logic [3:0]                DI,
    output logic [7:0]                WAVEAD,
    input  logic [3:0]                WAVEDT,
    output logic [7:0]                PCMOUT,
    output logic                      PCMSTB
);

    localparam int unsigned VIW = voice_idx_w(VOICES);
    localparam int unsigned SW  = sum_width(VOICES);
    localparam int unsigned SH  = $clog2(VOICES);
    localparam int unsigned DW  = $clog2(DIV);

    wsg_state_t       r_state;
    logic [DW-1:0]    r_div;
    logic [VIW-1:0]   r_v;
    logic [SW-1:0]    r_sum;
    logic [ACC_W-1:0] r_acc [VOICES];
    logic [7:0]       r_wavead;
    logic [7:0]       r_pcm;

    logic [ACC_W-1:0] w_freq;
    logic [2:0]       w_wave;
    logic [3:0]       w_vol;
    logic [ACC_W-1:0] w_acc;
    logic [7:0]       w_prod;
    logic [7:0]       w_mix;
    logic             w_tick;
    logic             w_last;
    logic             w_sat;

    namco_wsg_regs #(
        .VOICES (VOICES),
        .ACC_W  (ACC_W)
    ) u_regs (
        .i_clk   (MCLK),
        .i_rst_n (RESET_N),
        .i_wr    (WR),
        .i_ad    (AD),
        .i_di    (DI),
        .i_rd_v  (r_v),
        .o_freq  (w_freq),
        .o_wave  (w_wave),
        .o_vol   (w_vol)
    );

    // Tick fires on the wrap edge, so the first frame starts DIV cycles after reset.
    assign w_tick = (r_div == DW'(DIV - 1));
    assign w_last = (r_v == VIW'(VOICES - 1));
    assign w_acc  = r_acc[r_v];
    assign w_prod = 8'(WAVEDT) * 8'(w_vol);
    assign w_sat  = ((r_sum >> 8) != '0);

    always_comb begin
        if (MIX_SAT != 0) begin
            w_mix = w_sat ? 8'hFF : r_sum[7:0];
        end else begin
            w_mix = 8'(r_sum >> SH);
        end
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= ST_IDLE;
            r_div    <= '0;
            r_v      <= '0;
            r_sum    <= '0;
            r_wavead <= '0;
            r_pcm    <= '0;
            for (int unsigned v = 0; v < VOICES; v++) begin
                r_acc[v] <= '0;
            end
        end else begin
            r_div <= w_tick ? '0 : r_div + DW'(1);
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state <= ST_ADDR;
                        r_v     <= '0;
                        r_sum   <= '0;
                    end
                end
                ST_ADDR: begin
                    r_wavead <= {w_wave, w_acc[ACC_W-1 -: 5]};
                    if (EN) begin
                        r_acc[r_v] <= w_acc + w_freq;
                    end
                    r_state <= ST_WAIT;
                end
                ST_WAIT: r_state <= ST_MAC;
                ST_MAC: begin
                    r_sum <= r_sum + SW'(w_prod);
                    if (w_last) begin
                        r_state <= ST_OUT;
                    end else begin
                        r_v     <= r_v + VIW'(1);
                        r_state <= ST_ADDR;
                    end
                end
                ST_OUT: begin
                    r_pcm   <= EN ? w_mix : '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign WAVEAD = r_wavead;
    assign PCMOUT = r_pcm;
    assign PCMSTB = (r_state == ST_OUT);

endmodule

// File: tb/tb_namco_wsg_nv.sv
// Bench for namco_wsg_nv: two instances (truncating mix / ACC_W=20 and
// saturating mix / ACC_W=16) checked every cycle against a frame-timeline model.
module tb_namco_wsg_nv;

    localparam int NV  = 3;
    localparam int DIV = 20;

    logic       clk;
    logic       RESET_N, EN, WR;
    logic [4:0] AD;
    logic [3:0] DI;
    logic [7:0] wad_a, wad_b, pcm_a, pcm_b;
    logic [3:0] wdt_a, wdt_b;
    logic       stb_a, stb_b;
    logic [3:0] rom [256];

    int tests = 0;
    int fails = 0;

    namco_wsg_nv #(.VOICES(NV), .ACC_W(20), .DIV(DIV), .MIX_SAT(0)) u_a (
        .MCLK(clk), .RESET_N(RESET_N), .EN(EN), .WR(WR), .AD(AD), .DI(DI),
        .WAVEAD(wad_a), .WAVEDT(wdt_a), .PCMOUT(pcm_a), .PCMSTB(stb_a));

    namco_wsg_nv #(.VOICES(NV), .ACC_W(16), .DIV(DIV), .MIX_SAT(1)) u_b (
        .MCLK(clk), .RESET_N(RESET_N), .EN(EN), .WR(WR), .AD(AD), .DI(DI),
        .WAVEAD(wad_b), .WAVEDT(wdt_b), .PCMOUT(pcm_b), .PCMSTB(stb_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) wdt_a <= rom[wad_a];
    always @(posedge clk) wdt_b <= rom[wad_b];

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference model: edge n after reset, tick at every multiple of DIV,
    // voice v addressed on frame edge 3v+1, accumulated on 3v+3, output on 3*NV+1.
    int mn = 0;
    int m_acc  [2][NV];
    int m_freq [2][NV];
    int m_addr [2][NV];
    int m_sum  [2];
    int m_wave [NV];
    int m_vol  [NV];
    int e_wad  [2];
    int e_pcm  [2];

    function automatic int acc_w(input int i);
        return (i == 0) ? 20 : 16;
    endfunction

    initial begin : model
        int o, v, r, sh;
        forever begin
            @(posedge clk or negedge RESET_N);
            if (!RESET_N) begin
                mn = 0;
                for (int i = 0; i < 2; i++) begin
                    m_sum[i] = 0; e_wad[i] = 0; e_pcm[i] = 0;
                    for (int k = 0; k < NV; k++) begin
                        m_acc[i][k] = 0; m_freq[i][k] = 0; m_addr[i][k] = 0;
                    end
                end
                for (int k = 0; k < NV; k++) begin
                    m_wave[k] = 0; m_vol[k] = 0;
                end
            end else begin
                mn++;
                if (mn >= DIV) begin
                    o = mn % DIV;
                    for (int i = 0; i < 2; i++) begin
                        if (o == 1) m_sum[i] = 0;
                        for (int k = 0; k < NV; k++) begin
                            if (o == 3*k + 1) begin
                                m_addr[i][k] = m_wave[k]*32 + ((m_acc[i][k] >> (acc_w(i) - 5)) & 31);
                                e_wad[i] = m_addr[i][k];
                                if (EN) m_acc[i][k] = (m_acc[i][k] + m_freq[i][k]) & ((1 << acc_w(i)) - 1);
                            end
                            if (o == 3*k + 3) m_sum[i] += int'(rom[m_addr[i][k]]) * m_vol[k];
                        end
                        if (o == 3*NV + 1) begin
                            if (!EN) e_pcm[i] = 0;
                            else if (i == 0) e_pcm[i] = m_sum[i] / 4;
                            else e_pcm[i] = (m_sum[i] > 255) ? 255 : m_sum[i];
                        end
                    end
                end
                if (WR) begin
                    v = int'(AD) / 8;
                    r = int'(AD) % 8;
                    if (v < NV) begin
                        if (r <= 4) begin
                            sh = 4 * r;
                            for (int i = 0; i < 2; i++)
                                m_freq[i][v] = ((m_freq[i][v] & ~(32'hF << sh)) | (int'(DI) << sh))
                                               & ((1 << acc_w(i)) - 1);
                        end else if (r == 5) m_wave[v] = int'(DI) & 7;
                        else if (r == 6) m_vol[v] = int'(DI);
                    end
                end
            end
        end
    end

    initial begin : compare
        int es;
        forever begin
            @(negedge clk);
            es = ((mn >= DIV) && (mn % DIV == 3*NV + 1 - 1 + 1 - 1)) ? 1 : 0;
            chk("stb_a", int'(stb_a), es);
            chk("stb_b", int'(stb_b), es);
            chk("pcm_a", int'(pcm_a), e_pcm[0]);
            chk("pcm_b", int'(pcm_b), e_pcm[1]);
            chk("wad_a", int'(wad_a), e_wad[0]);
            chk("wad_b", int'(wad_b), e_wad[1]);
        end
    end

    task automatic go(input int x);
        while (mn < x) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic samp(input int x);
        go(x);
        @(negedge clk);
    endtask

    task automatic wr_at(input int x, input int v, input int r, input int d);
        go(x - 1);
        WR = 1'b1; AD = 5'(v*8 + r); DI = 4'(d);
        go(x);
        WR = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int f;
        RESET_N = 1'b0; EN = 1'b1; WR = 1'b0; AD = '0; DI = '0;
        for (int i = 0; i < 256; i++) rom[i] = 4'hF;
        repeat (2) @(posedge clk);
        #1 WR = 1'b1; AD = 5'b00110; DI = 4'hF;
        @(posedge clk); #1 AD = 5'b01110;
        @(posedge clk); #1 WR = 1'b0;
        @(negedge clk);
        chk("rst_pcm_a", int'(pcm_a), 0);
        chk("rst_stb_a", int'(stb_a), 0);
        chk("rst_wad_a", int'(wad_a), 0);
        chk("rst_pcm_b", int'(pcm_b), 0);
        @(posedge clk); #1 RESET_N = 1'b1;

        samp(DIV + 3*NV - 1); chk("first_stb_early", int'(stb_a), 0);
        samp(DIV + 3*NV);     chk("first_stb",       int'(stb_a), 1);
        samp(DIV + 3*NV + 1); chk("rst_regs_pcm",    int'(pcm_a), 0);
        samp(2*DIV + 3*NV);   chk("stb_period",      int'(stb_a), 1);

        wr_at(52, 0, 6, 15);
        samp(70); chk("v0_full_a", int'(pcm_a), 8'h38); chk("v0_full_b", int'(pcm_b), 8'hE1);
        wr_at(72, 1, 6, 15);
        samp(90); chk("v01_a", int'(pcm_a), 8'h70); chk("v01_sat_b", int'(pcm_b), 8'hFF);
        wr_at(92, 0, 6, 0);
        wr_at(94, 1, 6, 1);
        wr_at(96, 3, 6, 15);
        wr_at(98, 1, 7, 15);
        samp(110); chk("v1_vol1_a", int'(pcm_a), 8'h03); chk("v1_vol1_b", int'(pcm_b), 8'h0F);

        wr_at(112, 0, 3, 8);
        wr_at(114, 0, 5, 4'hA);
        for (int j = 0; j < 34; j++) begin
            samp(120 + 20*j + 1);
            chk("phase_a", int'(wad_a), 8'h40 + (j % 32));
            chk("phase_b", int'(wad_b), 8'h40 + ((16*j) % 32));
        end

        go(790); EN = 1'b0;
        for (int j = 0; j < 3; j++) begin
            f = 800 + 20*j;
            samp(f + 1);  chk("en_hold_a", int'(wad_a), 8'h42); chk("en_hold_b", int'(wad_b), 8'h40);
            samp(f + 10); chk("en_pcm_a", int'(pcm_a), 0);      chk("en_pcm_b", int'(pcm_b), 0);
        end
        go(850); EN = 1'b1;
        samp(861); chk("en_resume_a", int'(wad_a), 8'h42); chk("en_resume_b", int'(wad_b), 8'h40);
        samp(870); chk("en_pcm_on_a", int'(pcm_a), 8'h03); chk("en_pcm_on_b", int'(pcm_b), 8'h0F);
        samp(881); chk("en_next_a", int'(wad_a), 8'h43);   chk("en_next_b", int'(wad_b), 8'h50);

        wr_at(895, 2, 5, 1);
        wr_at(903, 2, 4, 1);
        samp(907); chk("midwr_a0", int'(wad_a), 8'h20); chk("midwr_b0", int'(wad_b), 8'h20);
        samp(927); chk("midwr_a1", int'(wad_a), 8'h22); chk("nib4_b",   int'(wad_b), 8'h20);

        go(935);
        for (int i = 0; i < 256; i++) rom[i] = 4'($urandom);
        for (int x = 936; x < 2400; x++) begin
            go(x);
            WR = ($urandom_range(2) == 0);
            AD = 5'($urandom);
            DI = 4'($urandom);
            EN = ($urandom_range(7) != 0);
        end
        go(2403); WR = 1'b0; EN = 1'b1;
        go(2404); RESET_N = 1'b0;
        #1;
        chk("midrst_wad_a", int'(wad_a), 0);
        chk("midrst_pcm_a", int'(pcm_a), 0);
        chk("midrst_stb_a", int'(stb_a), 0);
        chk("midrst_pcm_b", int'(pcm_b), 0);
        repeat (3) @(posedge clk);
        #1 RESET_N = 1'b1;
        samp(DIV + 3*NV - 1); chk("re_stb_early", int'(stb_b), 0);
        samp(DIV + 3*NV);     chk("re_stb",       int'(stb_b), 1);
        samp(DIV + 3*NV + 1); chk("re_pcm",       int'(pcm_b), 0);
        go(3*DIV + 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
